// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit RISC front end: widths, opcode map and instruction field positions.
package cpu_pkg;

    localparam int DATA_W    = 16;
    localparam int NUM_REGS  = 8;
    localparam int REG_SEL_W = $clog2(NUM_REGS);
    localparam int INSTR_W   = 16;
    localparam int ALU_OP_W  = 5;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_OR    = 4'h2,
        OP_XOR   = 4'h3,
        OP_AND   = 4'h4,
        OP_NOT   = 4'h5,
        OP_LOAD  = 4'h6,
        OP_STORE = 4'h7,
        OP_LDI   = 4'h8,
        OP_CMP   = 4'h9,
        OP_SHL   = 4'hA,
        OP_SHR   = 4'hB,
        OP_JMP   = 4'hC,
        OP_JMPC  = 4'hD,
        OP_RSV_E = 4'hE,
        OP_RSV_F = 4'hF
    } opcode_e;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int RD_MSB   = 11;
    localparam int RD_LSB   = 9;
    localparam int FLAG_BIT = 8;
    localparam int RA_MSB   = 7;
    localparam int RA_LSB   = 5;
    localparam int RB_MSB   = 4;
    localparam int RB_LSB   = 2;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

    // Stores, jumps and the reserved opcodes produce no result for rD.
    function automatic logic writes_rd(input logic [3:0] op);
        case (op)
            OP_STORE, OP_JMP, OP_JMPC, OP_RSV_E, OP_RSV_F: writes_rd = 1'b0;
            default:                                       writes_rd = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/instruction_decoder_register_file.sv
// 8-entry register file with a registered dual read port and one write port.
// Optional macro R0_ZERO_EN: r0 reads as zero and ignores writes.
module register_file
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 wr_enable,
    input  logic [REG_SEL_W-1:0] select_A,
    input  logic [REG_SEL_W-1:0] select_B,
    input  logic [REG_SEL_W-1:0] select_D,
    input  logic [DATA_W-1:0]    data_D,
    output logic [DATA_W-1:0]    data_A,
    output logic [DATA_W-1:0]    data_B
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              write_ok;
    logic [DATA_W-1:0] read_A;
    logic [DATA_W-1:0] read_B;

`ifdef R0_ZERO_EN
    assign write_ok = wr_enable && (select_D != '0);
    assign read_A   = (select_A == '0) ? '0 : regs[select_A];
    assign read_B   = (select_B == '0) ? '0 : regs[select_B];
`else
    assign write_ok = wr_enable;
    assign read_A   = regs[select_A];
    assign read_B   = regs[select_B];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (write_ok) begin
            regs[select_D] <= data_D;
        end
    end

    // Reads sample the pre-edge array, so a same-edge write is seen only on the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_A <= '0;
            data_B <= '0;
        end else if (enable) begin
            data_A <= read_A;
            data_B <= read_B;
        end
    end

endmodule

// File: rtl/instruction_decoder.sv
// Instruction decoder: latches decode fields of a 16-bit instruction and reads operands from the register file.
// Optional macro R0_ZERO_EN (handled inside register_file) hard-wires r0 to zero.
module instruction_decoder
    import cpu_pkg::*;
(
    input  logic                 I_clk,
    input  logic                 I_rst_n,
    input  logic                 I_enable,
    input  logic [INSTR_W-1:0]   I_instruction,
    input  logic                 I_rd_enable,
    input  logic                 I_wb_enable,
    input  logic [DATA_W-1:0]    I_wb_data,
    output logic [ALU_OP_W-1:0]  O_alu_opcode,
    output logic [REG_SEL_W-1:0] O_select_A,
    output logic [REG_SEL_W-1:0] O_select_B,
    output logic [REG_SEL_W-1:0] O_select_D,
    output logic [DATA_W-1:0]    O_immediate,
    output logic                 O_reg_write_enable,
    output logic [DATA_W-1:0]    O_data_A,
    output logic [DATA_W-1:0]    O_data_B
);

    logic unused_low_bits;
    assign unused_low_bits = ^I_instruction[1:0];

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_alu_opcode       <= '0;
            O_select_A         <= '0;
            O_select_B         <= '0;
            O_select_D         <= '0;
            O_immediate        <= '0;
            O_reg_write_enable <= 1'b0;
        end else if (I_enable) begin
            O_alu_opcode       <= {I_instruction[OPC_MSB:OPC_LSB], I_instruction[FLAG_BIT]};
            O_select_A         <= I_instruction[RA_MSB:RA_LSB];
            O_select_B         <= I_instruction[RB_MSB:RB_LSB];
            O_select_D         <= I_instruction[RD_MSB:RD_LSB];
            O_immediate        <= {I_instruction[IMM_MSB:IMM_LSB], I_instruction[IMM_MSB:IMM_LSB]};
            O_reg_write_enable <= writes_rd(I_instruction[OPC_MSB:OPC_LSB]);
        end
    end

    // Write-back is qualified by the currently latched decode, not the one arriving on this edge.
    register_file u_register_file (
        .clk       (I_clk),
        .rst_n     (I_rst_n),
        .enable    (I_rd_enable),
        .wr_enable (I_wb_enable & O_reg_write_enable),
        .select_A  (O_select_A),
        .select_B  (O_select_B),
        .select_D  (O_select_D),
        .data_D    (I_wb_data),
        .data_A    (O_data_A),
        .data_B    (O_data_B)
    );

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder: table-driven decode vectors plus register-file sequences.
module tb_instruction_decoder;

    logic        I_clk = 1'b0;
    logic        I_rst_n;
    logic        I_enable;
    logic [15:0] I_instruction;
    logic        I_rd_enable;
    logic        I_wb_enable;
    logic [15:0] I_wb_data;
    logic [4:0]  O_alu_opcode;
    logic [2:0]  O_select_A;
    logic [2:0]  O_select_B;
    logic [2:0]  O_select_D;
    logic [15:0] O_immediate;
    logic        O_reg_write_enable;
    logic [15:0] O_data_A;
    logic [15:0] O_data_B;

    int pass_count  = 0;
    int check_count = 0;

`ifdef R0_ZERO_EN
    localparam logic [15:0] EXP_R0 = 16'h0000;
`else
    localparam logic [15:0] EXP_R0 = 16'hFFFF;
`endif

    typedef struct {
        logic [15:0] instr;
        logic [4:0]  opcode;
        logic [2:0]  sel_d;
        logic [2:0]  sel_a;
        logic [2:0]  sel_b;
        logic [15:0] imm;
        logic        we;
    } decode_vec_t;

    decode_vec_t vecs [8];

    instruction_decoder dut (
        .I_clk              (I_clk),
        .I_rst_n            (I_rst_n),
        .I_enable           (I_enable),
        .I_instruction      (I_instruction),
        .I_rd_enable        (I_rd_enable),
        .I_wb_enable        (I_wb_enable),
        .I_wb_data          (I_wb_data),
        .O_alu_opcode       (O_alu_opcode),
        .O_select_A         (O_select_A),
        .O_select_B         (O_select_B),
        .O_select_D         (O_select_D),
        .O_immediate        (O_immediate),
        .O_reg_write_enable (O_reg_write_enable),
        .O_data_A           (O_data_A),
        .O_data_B           (O_data_B)
    );

    always #5 I_clk = ~I_clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Drive one cycle of inputs, clock it in, sample 1 time unit after the edge, then drop the strobes.
    task automatic applyStimulus(input logic en, input logic [15:0] instr, input logic rd,
                                 input logic wb, input logic [15:0] data);
        I_enable      = en;
        I_instruction = instr;
        I_rd_enable   = rd;
        I_wb_enable   = wb;
        I_wb_data     = data;
        @(posedge I_clk);
        #1;
        I_enable    = 1'b0;
        I_rd_enable = 1'b0;
        I_wb_enable = 1'b0;
    endtask

    task automatic writeReg(input logic [2:0] d, input logic [15:0] data);
        applyStimulus(1'b1, {4'h0, d, 9'h000}, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, data);
    endtask

    task automatic readRegs(input logic [2:0] a, input logic [2:0] b);
        applyStimulus(1'b1, {8'h00, a, b, 2'b00}, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    endtask

    task automatic checkDecodeZero(input string tag);
        checkOutput({tag, " opcode"}, {11'h0, O_alu_opcode}, 16'h0000);
        checkOutput({tag, " selA"}, {13'h0, O_select_A}, 16'h0000);
        checkOutput({tag, " selB"}, {13'h0, O_select_B}, 16'h0000);
        checkOutput({tag, " selD"}, {13'h0, O_select_D}, 16'h0000);
        checkOutput({tag, " imm"}, O_immediate, 16'h0000);
        checkOutput({tag, " we"}, {15'h0, O_reg_write_enable}, 16'h0000);
        checkOutput({tag, " dataA"}, O_data_A, 16'h0000);
        checkOutput({tag, " dataB"}, O_data_B, 16'h0000);
    endtask

    initial begin
        vecs[0] = '{16'h0388, 5'b00001, 3'd1, 3'd4, 3'd2, 16'h8888, 1'b1};
        vecs[1] = '{16'h7E48, 5'b01110, 3'd7, 3'd2, 3'd2, 16'h4848, 1'b0};
        vecs[2] = '{16'hC123, 5'b11001, 3'd0, 3'd1, 3'd0, 16'h2323, 1'b0};
        vecs[3] = '{16'hF0FF, 5'b11110, 3'd0, 3'd7, 3'd7, 16'hFFFF, 1'b0};
        vecs[4] = '{16'h8A5C, 5'b10000, 3'd5, 3'd2, 3'd7, 16'h5C5C, 1'b1};
        vecs[5] = '{16'hD000, 5'b11010, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0};
        vecs[6] = '{16'hB000, 5'b10110, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1};
        vecs[7] = '{16'hE000, 5'b11100, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0};

        I_rst_n = 1'b0;
        I_enable = 1'b0;
        I_instruction = 16'h0000;
        I_rd_enable = 1'b0;
        I_wb_enable = 1'b0;
        I_wb_data = 16'h0000;
        repeat (2) @(posedge I_clk);
        #1;
        checkDecodeZero("reset");
        I_rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vecs[i].instr, 1'b0, 1'b0, 16'h0000);
            checkOutput($sformatf("vec%0d opcode", i), {11'h0, O_alu_opcode}, {11'h0, vecs[i].opcode});
            checkOutput($sformatf("vec%0d selD", i), {13'h0, O_select_D}, {13'h0, vecs[i].sel_d});
            checkOutput($sformatf("vec%0d selA", i), {13'h0, O_select_A}, {13'h0, vecs[i].sel_a});
            checkOutput($sformatf("vec%0d selB", i), {13'h0, O_select_B}, {13'h0, vecs[i].sel_b});
            checkOutput($sformatf("vec%0d imm", i), O_immediate, vecs[i].imm);
            checkOutput($sformatf("vec%0d we", i), {15'h0, O_reg_write_enable}, {15'h0, vecs[i].we});
        end

        applyStimulus(1'b1, 16'h0388, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 16'hFFFF, 1'b0, 1'b0, 16'h0000);
        checkOutput("hold opcode", {11'h0, O_alu_opcode}, 16'h0001);
        checkOutput("hold selA", {13'h0, O_select_A}, 16'h0004);
        checkOutput("hold imm", O_immediate, 16'h8888);
        checkOutput("hold we", {15'h0, O_reg_write_enable}, 16'h0001);

        applyStimulus(1'b1, 16'h7E48, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234);
        readRegs(3'd7, 3'd7);
        checkOutput("store no write r7", O_data_A, 16'h0000);

        // Latched STORE blocks a write on the edge that decodes an ADD to r4.
        applyStimulus(1'b1, 16'h7E48, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b1, 16'h0800, 1'b0, 1'b1, 16'hBEEF);
        // Latched ADD r4 still writes on the edge that decodes a STORE.
        applyStimulus(1'b1, 16'h7A00, 1'b0, 1'b1, 16'h0BAD);
        readRegs(3'd4, 3'd4);
        checkOutput("pre-edge selD write r4", O_data_A, 16'h0BAD);

        writeReg(3'd0, 16'hFFFF);
        writeReg(3'd1, 16'hAAAA);
        writeReg(3'd2, 16'h5555);
        readRegs(3'd0, 3'd1);
        checkOutput("read r0", O_data_A, EXP_R0);
        checkOutput("read r1", O_data_B, 16'hAAAA);
        readRegs(3'd1, 3'd2);
        checkOutput("read r1 via A", O_data_A, 16'hAAAA);
        checkOutput("read r2 via B", O_data_B, 16'h5555);

        applyStimulus(1'b1, 16'h00E0, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        checkOutput("gated dataA", O_data_A, 16'hAAAA);
        checkOutput("gated dataB", O_data_B, 16'h5555);

        writeReg(3'd3, 16'h0011);
        applyStimulus(1'b1, 16'h0660, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'h00FF);
        checkOutput("same-edge old r3", O_data_A, 16'h0011);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        checkOutput("next read new r3", O_data_A, 16'h00FF);

        // Mid-run reset must clear outputs without waiting for a clock edge.
        #2;
        I_rst_n = 1'b0;
        #1;
        checkDecodeZero("async reset");
        @(negedge I_clk);
        I_rst_n = 1'b1;
        for (int r = 0; r < 8; r++) begin
            readRegs(3'(r), 3'(r));
            checkOutput($sformatf("post-reset r%0d A", r), O_data_A, 16'h0000);
            checkOutput($sformatf("post-reset r%0d B", r), O_data_B, 16'h0000);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
